// File: rtl/lcd_reader_if.sv
// Custom-instruction handshake plus LCD read-side pins for the lcd_reader block.
// The slave modport is the reader itself. The master modport is the CPU/pad side that drives it.
interface lcd_reader_if;
   logic        clk_en;
   logic        start;
   logic [31:0] dataa;
   logic [31:0] datab;
   logic [31:0] result;
   logic        done;
   logic        rs;
   logic        rw;
   logic        en;
   logic [7:0]  db_in;

   modport slave (
      input  clk_en, start, dataa, datab, db_in,
      output result, done, rs, rw, en
   );

   modport master (
      output clk_en, start, dataa, datab, db_in,
      input  result, done, rs, rw, en
   );
endinterface

// File: rtl/lcd_reader.sv
// HD44780 read-cycle custom instruction: one read, or busy-flag polling with a bounded read count.
// The LCD bus is released (tristated) by the top level whenever rw=1.
//
// state   | meaning
// --------+---------------------------------------------------------
// IDLE    | waiting for start; rw=0, en=0
// SETUP   | rs/rw stable, en low, counting address setup
// EN_HIGH | en high; db_in captured on the last cycle
// HOLD    | en low, rs/rw held; decides poll-again or finish
// GAP     | idle spacing between polling reads, rw still 1
// FINISH  | done pulse cycle, result already updated, rw=0
module lcd_reader #(
   parameter int SETUP_CYC   = 3,
   parameter int EN_HIGH_CYC = 25,
   parameter int HOLD_CYC    = 2,
   parameter int GAP_CYC     = 25,
   parameter int MAX_POLLS   = 1000
) (
   input logic         clk,
   input logic         reset,
   lcd_reader_if.slave bus
);

   localparam logic [15:0] SETUP_LAST = 16'(SETUP_CYC - 1);
   localparam logic [15:0] EN_LAST    = 16'(EN_HIGH_CYC - 1);
   localparam logic [15:0] HOLD_LAST  = 16'(HOLD_CYC - 1);
   localparam logic [15:0] GAP_LAST   = 16'(GAP_CYC - 1);
   localparam logic [15:0] POLL_MAX   = 16'(MAX_POLLS);

   typedef enum logic [2:0] {
      S_IDLE,
      S_SETUP,
      S_EN_HIGH,
      S_HOLD,
      S_GAP,
      S_FINISH
   } state_t;

   state_t      r_state;
   logic [15:0] r_cnt;
   logic [15:0] r_reads;
   logic [7:0]  r_byte;
   logic        r_poll;
   logic        r_rs;
   logic        r_rw;
   logic        r_en;
   logic        r_done;
   logic [31:0] r_result;

   logic [15:0] w_reads_inc;
   logic        w_again;
   logic        w_timeout;
   logic        w_unused;

   assign w_reads_inc = (r_reads == 16'hFFFF) ? r_reads : r_reads + 16'd1;
   assign w_again     = r_poll && r_byte[7] && (r_reads < POLL_MAX);
   assign w_timeout   = r_poll && r_byte[7] && (r_reads == POLL_MAX);
   assign w_unused    = ^{bus.datab, bus.dataa[31:2]};

   // done is qualified by clk_en so the CPU sees it on exactly one enabled cycle,
   // even when clk_en is low in the cycle right after the FINISH transition.
   assign bus.done   = r_done & bus.clk_en;
   assign bus.result = r_result;
   assign bus.rs     = r_rs;
   assign bus.rw     = r_rw;
   assign bus.en     = r_en;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state  <= S_IDLE;
         r_cnt    <= 16'd0;
         r_reads  <= 16'd0;
         r_byte   <= 8'd0;
         r_poll   <= 1'b0;
         r_rs     <= 1'b0;
         r_rw     <= 1'b0;
         r_en     <= 1'b0;
         r_done   <= 1'b0;
         r_result <= 32'd0;
      end else if (bus.clk_en) begin
         case (r_state)
            S_IDLE: begin
               r_done <= 1'b0;
               if (bus.start) begin
                  r_rs    <= bus.dataa[0];
                  r_poll  <= bus.dataa[1];
                  r_rw    <= 1'b1;
                  r_reads <= 16'd0;
                  r_cnt   <= 16'd0;
                  r_state <= S_SETUP;
               end
            end
            S_SETUP: begin
               if (r_cnt == SETUP_LAST) begin
                  r_cnt   <= 16'd0;
                  r_en    <= 1'b1;
                  r_state <= S_EN_HIGH;
               end else begin
                  r_cnt <= r_cnt + 16'd1;
               end
            end
            S_EN_HIGH: begin
               if (r_cnt == EN_LAST) begin
                  r_cnt   <= 16'd0;
                  r_byte  <= bus.db_in;
                  r_en    <= 1'b0;
                  r_reads <= w_reads_inc;
                  r_state <= S_HOLD;
               end else begin
                  r_cnt <= r_cnt + 16'd1;
               end
            end
            S_HOLD: begin
               if (r_cnt == HOLD_LAST) begin
                  r_cnt <= 16'd0;
                  if (w_again) begin
                     r_state <= S_GAP;
                  end else begin
                     // Completion is registered here so done and rw=0 land in the same cycle.
                     r_rw     <= 1'b0;
                     r_result <= {r_reads, 7'b0, w_timeout, r_byte};
                     r_done   <= 1'b1;
                     r_state  <= S_FINISH;
                  end
               end else begin
                  r_cnt <= r_cnt + 16'd1;
               end
            end
            S_GAP: begin
               if (r_cnt == GAP_LAST) begin
                  r_cnt   <= 16'd0;
                  r_state <= S_SETUP;
               end else begin
                  r_cnt <= r_cnt + 16'd1;
               end
            end
            S_FINISH: begin
               r_done  <= 1'b0;
               r_state <= S_IDLE;
            end
            default: begin
               r_state <= S_IDLE;
               r_en    <= 1'b0;
               r_rw    <= 1'b0;
               r_done  <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_lcd_reader.sv
// Self-checking bench for lcd_reader: table vectors, randomized transactions against a
// timing/result model expressed in enabled-cycle counts, plus reset and start-in-GAP sequences.
module tb_lcd_reader;

   localparam int SETUP = 3;
   localparam int ENH   = 25;
   localparam int HOLD  = 2;
   localparam int GAP   = 25;
   localparam int MAXP  = 4;
   localparam int PER   = GAP + SETUP + ENH + HOLD;

   logic clk;
   logic rst;
   lcd_reader_if bus();

   lcd_reader #(
      .SETUP_CYC(SETUP), .EN_HIGH_CYC(ENH), .HOLD_CYC(HOLD),
      .GAP_CYC(GAP), .MAX_POLLS(MAXP)
   ) dut (
      .clk  (clk),
      .reset(rst),
      .bus  (bus)
   );

   initial clk = 1'b0;
   always #10 clk = ~clk;

   int n_cmp = 0;
   int n_bad = 0;

   typedef struct {
      logic [31:0]     dataa;
      logic [7:0][7:0] db;
      int              mode;
      int              inject;
      logic [31:0]     exp_res;
      int              exp_dt;
   } vec_t;

   vec_t vecs [8];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h, expected %h", name, act, exp);
      end
   endtask

   function automatic logic [7:0][7:0] mk(input logic [7:0] a, input logic [7:0] b,
                                         input logic [7:0] c, input logic [7:0] d);
      mk = {d, d, d, d, d, c, b, a};
   endfunction

   // Reference: reads continue while polling and the busy bit is set, up to MAXP reads.
   function automatic void model(input logic [31:0] da, input logic [7:0][7:0] db,
                                 output logic [31:0] res, output int dt);
      int         n;
      logic [7:0] b;
      logic       to;
      n = 1;
      b = db[0];
      if (da[1]) begin
         while (b[7] && n < MAXP) begin
            b = db[(n > 7) ? 7 : n];
            n++;
         end
      end
      to  = da[1] && b[7];
      res = {16'(n), 7'b0, to, b};
      dt  = 1 + (n - 1) * PER + SETUP + ENH + HOLD;
   endfunction

   // t counts enabled cycles since the start edge; every output is a function of t.
   task automatic run(input string name, input logic [31:0] da, input logic [7:0][7:0] db,
                      input int mode, input int inject, input logic [31:0] exp_res, input int dt);
      int   t, n, k, ph, cyc;
      int   bad_en, bad_rw, bad_rs, bad_done, bad_res, bad_excl, done_cnt, en_clk;
      logic ce, exp_en;
      n = int'(exp_res[31:16]);
      bad_en = 0; bad_rw = 0; bad_rs = 0; bad_done = 0; bad_res = 0; bad_excl = 0;
      done_cnt = 0; en_clk = 0; cyc = 0;
      bus.clk_en = 1'b1;
      bus.dataa  = da;
      bus.datab  = $urandom;
      bus.db_in  = db[0];
      bus.start  = 1'b1;
      @(posedge clk); #1;
      bus.start = 1'b0;
      t = 1;
      while (t <= dt && cyc < 3 * dt + 50) begin
         case (mode)
            0:       ce = 1'b1;
            1:       ce = cyc[0];
            default: ce = ($urandom_range(0, 3) != 0);
         endcase
         k  = (t - 1) / PER;
         ph = (t - 1) % PER;
         bus.db_in  = db[(k > 7) ? 7 : k];
         bus.clk_en = ce;
         bus.start  = (t == inject);
         #2;
         exp_en = (ph >= SETUP) && (ph < SETUP + ENH) && (k < n);
         if (bus.en !== exp_en) bad_en++;
         if (bus.rw !== (t < dt)) bad_rw++;
         if (bus.rs !== da[0]) bad_rs++;
         if (bus.done !== (t == dt && ce)) bad_done++;
         if (t == dt && ce && bus.result !== exp_res) bad_res++;
         if (bus.en && !bus.rw) bad_excl++;
         done_cnt += int'(bus.done);
         en_clk   += int'(bus.en);
         @(posedge clk); #1;
         if (ce) t++;
         cyc++;
      end
      bus.clk_en = 1'b1;
      bus.start  = 1'b0;
      #1;
      check({name, ":finished_in_budget"}, (t > dt) ? 32'd1 : 32'd0, 32'd1);
      check({name, ":en_wave"}, bad_en, 0);
      check({name, ":rw_wave"}, bad_rw, 0);
      check({name, ":rs_stable"}, bad_rs, 0);
      check({name, ":done_wave"}, bad_done, 0);
      check({name, ":result_at_done"}, bad_res, 0);
      check({name, ":en_only_with_rw"}, bad_excl, 0);
      check({name, ":done_count"}, done_cnt, 1);
      if (mode == 0) check({name, ":en_clk_cycles"}, en_clk, n * ENH);
      if (mode == 1) check({name, ":en_clk_cycles"}, en_clk, 2 * n * ENH);
      check({name, ":result_held"}, bus.result, exp_res);
      check({name, ":done_low_after"}, bus.done, 0);
   endtask

   initial begin
      logic [31:0]     r_res;
      logic [7:0][7:0] r_db;
      logic [31:0]     r_da;
      int              r_dt, rdone, r_mode;

      vecs[0] = '{32'h1, mk(8'h41, 8'h41, 8'h41, 8'h41), 0, 0,  32'h0001_0041, 31};
      vecs[1] = '{32'h3, mk(8'h80, 8'h80, 8'h05, 8'h05), 0, 0,  32'h0003_0005, 141};
      vecs[2] = '{32'h3, mk(8'hFF, 8'hFF, 8'hFF, 8'hFF), 0, 0,  32'h0004_01FF, 196};
      vecs[3] = '{32'h1, mk(8'h41, 8'h41, 8'h41, 8'h41), 1, 0,  32'h0001_0041, 31};
      vecs[4] = '{32'h0, mk(8'h9A, 8'h9A, 8'h9A, 8'h9A), 0, 0,  32'h0001_009A, 31};
      vecs[5] = '{32'h3, mk(8'h7F, 8'h80, 8'h80, 8'h80), 2, 0,  32'h0001_007F, 31};
      vecs[6] = '{32'h3, mk(8'h80, 8'h05, 8'h05, 8'h05), 0, 40, 32'h0002_0005, 86};
      vecs[7] = '{32'hFFFF_FFFE, mk(8'h80, 8'h80, 8'h80, 8'h12), 2, 0, 32'h0004_0012, 196};

      rst = 1'b1;
      bus.clk_en = 1'b0;
      bus.start  = 1'b0;
      bus.dataa  = '0;
      bus.datab  = '0;
      bus.db_in  = '0;
      #25;
      check("reset:result", bus.result, 0);
      check("reset:done", bus.done, 0);
      check("reset:en", bus.en, 0);
      check("reset:rw", bus.rw, 0);
      check("reset:rs", bus.rs, 0);
      @(negedge clk) rst = 1'b0;
      @(posedge clk); #1;

      for (int i = 0; i < 8; i++)
         run($sformatf("vec%0d", i), vecs[i].dataa, vecs[i].db, vecs[i].mode,
             vecs[i].inject, vecs[i].exp_res, vecs[i].exp_dt);

      // Reset while en is high: outputs drop asynchronously, no done, next read is clean.
      bus.dataa  = 32'h1;
      bus.db_in  = 8'h41;
      bus.clk_en = 1'b1;
      bus.start  = 1'b1;
      @(posedge clk); #1;
      bus.start = 1'b0;
      repeat (9) @(posedge clk);
      #5;
      check("rst_mid:en_before", bus.en, 1);
      rst = 1'b1;
      #1;
      check("rst_mid:en", bus.en, 0);
      check("rst_mid:rw", bus.rw, 0);
      check("rst_mid:done", bus.done, 0);
      check("rst_mid:result", bus.result, 0);
      rdone = 0;
      repeat (3) begin
         @(posedge clk); #1;
         rdone += int'(bus.done);
      end
      check("rst_mid:no_done", rdone, 0);
      @(negedge clk) rst = 1'b0;
      @(posedge clk); #1;
      run("after_rst", vecs[0].dataa, vecs[0].db, 0, 0, vecs[0].exp_res, vecs[0].exp_dt);

      for (int i = 0; i < 12; i++) begin
         r_da = $urandom;
         for (int j = 0; j < 8; j++) r_db[j] = 8'($urandom_range(0, 255));
         r_mode = $urandom_range(0, 2);
         model(r_da, r_db, r_res, r_dt);
         run($sformatf("rand%0d", i), r_da, r_db, r_mode, 0, r_res, r_dt);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
